// File: rtl/pulse_sample_logger.sv
// Queues 32-bit pulse-count samples and writes each one as two 16-bit words
// into an SDRAM ring region through the arbiter write port.
module pulse_sample_logger #(
    parameter logic [23:0] BASE_ADDR    = 24'h100000,
    parameter int unsigned RING_SAMPLES = 1024,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned IW           = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          iDataUpdate,
    input  logic [31:0]                   iPulseCount,
    output logic                          oWr_Req,
    output logic [23:0]                   oWr_Addr,
    output logic [15:0]                   oWr_Data,
    input  logic                          iWr_Done,
    output logic [IW-1:0]                 oWrIdx,
    output logic                          oWrapped,
    output logic                          oSampleCommit,
    output logic [15:0]                   oDropCnt,
    output logic [$clog2(FIFO_DEPTH):0]   oFifoLevel
);

    localparam int unsigned      FAW      = $clog2(FIFO_DEPTH);
    localparam logic [FAW:0]     FULL_LVL = (FAW+1)'(FIFO_DEPTH);
    localparam logic [IW-1:0]    LAST_IDX = IW'(RING_SAMPLES - 1);

    typedef enum logic [2:0] {IDLE, WR_LO, GAP, WR_HI, COMMIT} state_t;

    state_t         state, state_next;
    logic [31:0]    fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0] rd_ptr, wr_ptr;
    logic [15:0]    hold_hi;
    logic           pop_c, push_c, drop_c;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
    assign pop_c  = (state == IDLE) && (oFifoLevel != '0);
    assign push_c = iDataUpdate && en && ((oFifoLevel != FULL_LVL) || pop_c);
    assign drop_c = iDataUpdate && en && !push_c;

    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= iPulseCount;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            oFifoLevel <= '0;
            oDropCnt   <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + FAW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + FAW'(1);
            case ({push_c, pop_c})
                2'b10:   oFifoLevel <= oFifoLevel + (FAW+1)'(1);
                2'b01:   oFifoLevel <= oFifoLevel - (FAW+1)'(1);
                default: oFifoLevel <= oFifoLevel;
            endcase
            if (drop_c && (oDropCnt != 16'hFFFF)) oDropCnt <= oDropCnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop_c)    state_next = WR_LO;
            WR_LO:   if (iWr_Done) state_next = GAP;
            GAP:                   state_next = WR_HI;
            WR_HI:   if (iWr_Done) state_next = COMMIT;
            COMMIT:                state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // The low half goes straight into oWr_Data on pop; only the high half is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_hi       <= '0;
            oWr_Req       <= 1'b0;
            oWr_Addr      <= '0;
            oWr_Data      <= '0;
            oWrIdx        <= '0;
            oWrapped      <= 1'b0;
            oSampleCommit <= 1'b0;
        end else begin
            oWr_Req       <= (state_next == WR_LO) || (state_next == WR_HI);
            oSampleCommit <= (state_next == COMMIT);
            if (pop_c) begin
                hold_hi  <= fifo_mem[rd_ptr][31:16];
                oWr_Addr <= BASE_ADDR + 24'({oWrIdx, 1'b0});
                oWr_Data <= fifo_mem[rd_ptr][15:0];
            end
            if (state == GAP) begin
                oWr_Addr <= BASE_ADDR + 24'({oWrIdx, 1'b1});
                oWr_Data <= hold_hi;
            end
            if (state == COMMIT) begin
                oWrIdx <= oWrIdx + IW'(1);
                if (oWrIdx == LAST_IDX) oWrapped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_sample_logger.sv
// Bench for pulse_sample_logger: directed scenarios with random sample data,
// checked against a sample-level queue model of the ring writer.
module tb_pulse_sample_logger;

    localparam logic [23:0] BASE  = 24'h100000;
    localparam int          RING  = 4;
    localparam int          DEPTH = 8;
    localparam int          IW    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        iDataUpdate = 1'b0;
    logic [31:0] iPulseCount = '0;
    logic        iWr_Done = 1'b0;
    logic        oWr_Req;
    logic [23:0] oWr_Addr;
    logic [15:0] oWr_Data;
    logic [IW-1:0] oWrIdx;
    logic        oWrapped;
    logic        oSampleCommit;
    logic [15:0] oDropCnt;
    logic [3:0]  oFifoLevel;

    pulse_sample_logger #(
        .BASE_ADDR(BASE), .RING_SAMPLES(RING), .FIFO_DEPTH(DEPTH), .IW(IW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .iDataUpdate(iDataUpdate),
        .iPulseCount(iPulseCount), .oWr_Req(oWr_Req), .oWr_Addr(oWr_Addr),
        .oWr_Data(oWr_Data), .iWr_Done(iWr_Done), .oWrIdx(oWrIdx),
        .oWrapped(oWrapped), .oSampleCommit(oSampleCommit),
        .oDropCnt(oDropCnt), .oFifoLevel(oFifoLevel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model: samples accepted but not yet committed, in order.
    logic [31:0] exp_q[$];
    int          commits   = 0;
    int          exp_drops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " req"}, oWr_Req, 0);
        chk({tag, " addr"}, oWr_Addr, 0);
        chk({tag, " data"}, oWr_Data, 0);
        chk({tag, " idx"}, oWrIdx, 0);
        chk({tag, " wrapped"}, oWrapped, 0);
        chk({tag, " commit"}, oSampleCommit, 0);
        chk({tag, " drops"}, oDropCnt, 0);
        chk({tag, " level"}, oFifoLevel, 0);
    endtask

    // One strobe; with the writer busy, capacity is the FIFO plus the holding slot.
    task automatic strobe(input logic [31:0] v);
        iDataUpdate = 1'b1;
        iPulseCount = v;
        if (en) begin
            if (exp_q.size() < DEPTH + 1) exp_q.push_back(v);
            else exp_drops++;
        end
        tick();
        iDataUpdate = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (oWr_Req !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, " req_seen"}, oWr_Req, 1);
    endtask

    task automatic serve_word(input string tag, input logic [23:0] a,
                              input logic [15:0] d, input int dly);
        wait_req(tag);
        chk({tag, " addr"}, oWr_Addr, a);
        chk({tag, " data"}, oWr_Data, d);
        repeat (dly - 1) tick();
        chk({tag, " req_held"}, oWr_Req, 1);
        iWr_Done = 1'b1;
        tick();
        iWr_Done = 1'b0;
        chk({tag, " req_drop"}, oWr_Req, 0);
    endtask

    task automatic serve_sample(input int dly, input bit inject, input logic [31:0] inj_val);
        logic [31:0] s;
        logic [23:0] a;
        s = exp_q[0];
        a = BASE + 24'(2 * (commits % RING));
        serve_word("lo", a, s[15:0], dly);
        serve_word("hi", a + 24'd1, s[31:16], dly);
        chk("commit_pulse", oSampleCommit, 1);
        void'(exp_q.pop_front());
        commits++;
        tick();
        chk("commit_once", oSampleCommit, 0);
        chk("wr_idx", oWrIdx, 32'(commits % RING));
        chk("wrapped", oWrapped, 32'(commits >= RING));
        if (inject) strobe(inj_val);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        en  = 1'b1;
        tick();

        // Single sample with first-transaction latency
        strobe(32'hDEADBEEF);
        chk("lat level", oFifoLevel, 1);
        chk("lat req_low", oWr_Req, 0);
        tick();
        chk("lat req_high", oWr_Req, 1);
        serve_sample(3, 1'b0, '0);
        chk("single idx", oWrIdx, 1);
        chk("single level", oFifoLevel, 0);

        // Ring wrap: five more samples, six in total on a four-slot ring
        repeat (5) begin
            strobe($urandom);
            serve_sample(int'($urandom_range(1, 4)), 1'b0, '0);
        end
        chk("wrap idx", oWrIdx, 2);
        chk("wrap flag", oWrapped, 1);

        // Arbiter stall while twelve strobes arrive
        for (int i = 0; i < 12; i++) begin
            strobe($urandom);
            repeat (9) tick();
        end
        repeat (80) tick();
        chk("stall req", oWr_Req, 1);
        chk("stall level", oFifoLevel, DEPTH);
        chk("stall drops", oDropCnt, exp_drops);
        chk("stall queued", exp_q.size(), DEPTH + 1);

        // Release; a strobe lands on the IDLE pop cycle with the FIFO full
        serve_sample(1, 1'b1, $urandom);
        chk("popfull level", oFifoLevel, DEPTH);
        chk("popfull drops", oDropCnt, exp_drops);
        while (exp_q.size() > 0) serve_sample(int'($urandom_range(1, 3)), 1'b0, '0);
        chk("drain level", oFifoLevel, 0);

        // en dropped mid-sample
        strobe($urandom);
        wait_req("en_lo");
        en = 1'b0;
        serve_sample(2, 1'b0, '0);
        repeat (3) begin
            strobe($urandom);
            chk("en_off level", oFifoLevel, 0);
        end
        repeat (4) tick();
        chk("en_off req", oWr_Req, 0);
        chk("en_off drops", oDropCnt, exp_drops);
        en = 1'b1;

        // Asynchronous reset during the high-word request
        strobe($urandom);
        v = exp_q[0];
        serve_word("rst_lo", BASE + 24'(2 * (commits % RING)), v[15:0], 2);
        wait_req("rst_hi");
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        exp_q.delete();
        commits   = 0;
        exp_drops = 0;
        tick();
        rst = 1'b0;
        tick();
        strobe($urandom);
        serve_sample(2, 1'b0, '0);
        chk("post_rst idx", oWrIdx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
